// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with registered result, N/V/C/Z flags and a valid pulse.
// Single-cycle ops (NOP/ADD/SUB/AND/OR/XOR/SHL1) complete one edge after acceptance.
// Optional macro ALU_SEQ_MUL_EN enables a multi-cycle shift-add multiplier on
// opcode 111; without it opcode 111 behaves like NOP and o_ready is tied high.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [2:0]       i_control,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_din_a,
  input  logic [WIDTH-1:0] i_din_b,
  output logic             o_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_dout,
  output logic [3:0]       o_flags
);

  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_SHL1 = 3'b110;

  logic [WIDTH-1:0] doutQ;
  logic [3:0]       flagsQ;
  logic             validQ;

  logic [WIDTH:0]   sumFull;
  logic [WIDTH:0]   diffFull;
  logic [WIDTH-1:0] aluRes;
  logic             aluC;
  logic             aluV;
  logic [3:0]       aluFlags;

  // Single-cycle datapath: result and flags for every opcode except the multiplier
  always_comb begin
    sumFull  = {1'b0, i_din_a} + {1'b0, i_din_b};
    diffFull = {1'b0, i_din_a} - {1'b0, i_din_b};
    aluRes   = '0;
    aluC     = 1'b0;
    aluV     = 1'b0;
    case (i_control)
      OP_ADD: begin
        aluRes = sumFull[WIDTH-1:0];
        aluC   = sumFull[WIDTH];
        aluV   = (i_din_a[WIDTH-1] == i_din_b[WIDTH-1]) &&
                 (sumFull[WIDTH-1] != i_din_a[WIDTH-1]);
      end
      OP_SUB: begin
        aluRes = diffFull[WIDTH-1:0];
        aluC   = diffFull[WIDTH];
        aluV   = (i_din_a[WIDTH-1] != i_din_b[WIDTH-1]) &&
                 (diffFull[WIDTH-1] != i_din_a[WIDTH-1]);
      end
      OP_AND:  aluRes = i_din_a & i_din_b;
      OP_OR:   aluRes = i_din_a | i_din_b;
      OP_XOR:  aluRes = i_din_a ^ i_din_b;
      OP_SHL1: begin
        aluRes = {i_din_a[WIDTH-2:0], 1'b0};
        aluC   = i_din_a[WIDTH-1];
      end
      default: aluRes = '0;
    endcase
    aluFlags = {aluRes[WIDTH-1], aluV, aluC, (aluRes == '0)};
  end

`ifdef ALU_SEQ_MUL_EN
  localparam logic [2:0] OP_MUL = 3'b111;
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_t;

  state_t             stateQ;
  logic               readyQ;
  logic [2*WIDTH-1:0] mcandQ;
  logic [2*WIDTH-1:0] accQ;
  logic [WIDTH-1:0]   mplierQ;
  logic [CNT_W-1:0]   cntQ;
  logic [2*WIDTH-1:0] productD;

  // Partial product for the current iteration; on the last one it is the full product
  always_comb begin
    productD = accQ + (mplierQ[0] ? mcandQ : '0);
  end

  // Control FSM: single-cycle ops complete from IDLE, MUL iterates WIDTH times then returns
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      stateQ  <= S_IDLE;
      readyQ  <= 1'b1;
      mcandQ  <= '0;
      accQ    <= '0;
      mplierQ <= '0;
      cntQ    <= '0;
      doutQ   <= '0;
      flagsQ  <= '0;
      validQ  <= 1'b0;
    end else begin
      validQ <= 1'b0;
      case (stateQ)
        S_IDLE: begin
          if (i_load) begin
            if (i_control == OP_MUL) begin
              stateQ  <= S_MUL;
              readyQ  <= 1'b0;
              mcandQ  <= {{WIDTH{1'b0}}, i_din_a};
              mplierQ <= i_din_b;
              accQ    <= '0;
              cntQ    <= '0;
            end else begin
              doutQ  <= aluRes;
              flagsQ <= aluFlags;
              validQ <= 1'b1;
            end
          end
        end
        S_MUL: begin
          accQ    <= productD;
          mcandQ  <= mcandQ << 1;
          mplierQ <= mplierQ >> 1;
          cntQ    <= cntQ + CNT_W'(1);
          if (cntQ == CNT_LAST) begin
            stateQ <= S_IDLE;
            readyQ <= 1'b1;
            cntQ   <= '0;
            doutQ  <= productD[WIDTH-1:0];
            flagsQ <= {productD[WIDTH-1], 1'b0, |productD[2*WIDTH-1:WIDTH],
                       (productD[WIDTH-1:0] == '0)};
            validQ <= 1'b1;
          end
        end
      endcase
    end
  end

  assign o_ready = readyQ;
`else
  // Result register: every accepted load completes on the next edge
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      doutQ  <= '0;
      flagsQ <= '0;
      validQ <= 1'b0;
    end else begin
      validQ <= i_load;
      if (i_load) begin
        doutQ  <= aluRes;
        flagsQ <= aluFlags;
      end
    end
  end

  assign o_ready = 1'b1;
`endif

  assign o_valid = validQ;
  assign o_dout  = doutQ;
  assign o_flags = flagsQ;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed scoreboard bench for alu_seq (WIDTH=8).
// Expected results are queued when a load is driven and popped when o_valid rises;
// the MUL tests are included when ALU_SEQ_MUL_EN is defined.
module tb_alu_seq;
  localparam int WIDTH = 8;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_SHL1 = 3'b110;
  localparam logic [2:0] OP_MUL  = 3'b111;

  typedef struct {
    int              due;
    logic [WIDTH-1:0] dout;
    logic [3:0]      flags;
    string           tag;
  } exp_t;

  logic             clk = 1'b0;
  logic             i_reset;
  logic [2:0]       i_control;
  logic             i_load;
  logic [WIDTH-1:0] i_din_a;
  logic [WIDTH-1:0] i_din_b;
  logic             o_ready;
  logic             o_valid;
  logic [WIDTH-1:0] o_dout;
  logic [3:0]       o_flags;

  exp_t             expQ[$];
  int               cycleCount = 0;
  int               checkCount = 0;
  int               passCount  = 0;
  bit               holdOn     = 1'b0;
  logic [WIDTH-1:0] modelDout  = '0;
  logic [3:0]       modelFlags = '0;

  alu_seq #(.WIDTH(WIDTH)) dut (
    .i_clk     (clk),
    .i_reset   (i_reset),
    .i_control (i_control),
    .i_load    (i_load),
    .i_din_a   (i_din_a),
    .i_din_b   (i_din_b),
    .o_ready   (o_ready),
    .o_valid   (o_valid),
    .o_dout    (o_dout),
    .o_flags   (o_flags)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Scoreboard check at the sampling point: pop on o_valid, flag missing or unexpected results
  task automatic checkOutput();
    exp_t e;
    if (o_valid === 1'b1) begin
      if (expQ.size() == 0) begin
        checkVal("unexpected_valid", {31'b0, o_valid}, 32'd0);
      end else begin
        e = expQ.pop_front();
        checkVal({e.tag, "_cycle"}, cycleCount, e.due);
        checkVal({e.tag, "_dout"}, {24'b0, o_dout}, {24'b0, e.dout});
        checkVal({e.tag, "_flags"}, {28'b0, o_flags}, {28'b0, e.flags});
        modelDout  = e.dout;
        modelFlags = e.flags;
      end
    end else begin
      if (expQ.size() != 0 && expQ[0].due <= cycleCount) begin
        e = expQ.pop_front();
        checkVal({e.tag, "_missing_valid"}, {31'b0, o_valid}, 32'd1);
      end
      if (holdOn) begin
        checkVal("hold_dout", {24'b0, o_dout}, {24'b0, modelDout});
        checkVal("hold_flags", {28'b0, o_flags}, {28'b0, modelFlags});
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    checkOutput();
    i_load = 1'b0;
  endtask

  task automatic driveLoad(input logic [2:0] op, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b);
    i_control = op;
    i_din_a   = a;
    i_din_b   = b;
    i_load    = 1'b1;
  endtask

  // edges: number of clock edges from acceptance (inclusive) until the result is visible
  task automatic applyStimulus(input logic [2:0] op, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] expDout,
                               input logic [3:0] expFlags, input int edges, input string tag);
    exp_t e;
    driveLoad(op, a, b);
    e.due   = cycleCount + edges;
    e.dout  = expDout;
    e.flags = expFlags;
    e.tag   = tag;
    expQ.push_back(e);
  endtask

  initial begin
    i_reset   = 1'b1;
    i_load    = 1'b0;
    i_control = OP_NOP;
    i_din_a   = '0;
    i_din_b   = '0;

    tick();
    tick();
    checkVal("reset_dout", {24'b0, o_dout}, 32'h00);
    checkVal("reset_flags", {28'b0, o_flags}, 32'h0);
    checkVal("reset_valid", {31'b0, o_valid}, 32'd0);
    checkVal("reset_ready", {31'b0, o_ready}, 32'd1);

    driveLoad(OP_ADD, 8'h01, 8'h01);
    tick();
    checkVal("rstload_valid", {31'b0, o_valid}, 32'd0);
    i_reset = 1'b0;
    holdOn  = 1'b1;
    tick();
    checkVal("rstload_valid_after", {31'b0, o_valid}, 32'd0);
    checkVal("idle_ready", {31'b0, o_ready}, 32'd1);

    applyStimulus(OP_ADD, 8'h7F, 8'h01, 8'h80, 4'b1100, 1, "add_7f_01");
    tick();
    applyStimulus(OP_ADD, 8'hFF, 8'h01, 8'h00, 4'b0011, 1, "add_ff_01");
    tick();
    applyStimulus(OP_SUB, 8'h03, 8'h05, 8'hFE, 4'b1010, 1, "sub_03_05");
    tick();
    applyStimulus(OP_SUB, 8'h80, 8'h01, 8'h7F, 4'b0100, 1, "sub_80_01");
    tick();
    applyStimulus(OP_AND, 8'hF0, 8'h0F, 8'h00, 4'b0001, 1, "and_f0_0f");
    tick();
    applyStimulus(OP_SHL1, 8'h81, 8'h5A, 8'h02, 4'b0010, 1, "shl1_81");
    tick();
    applyStimulus(OP_OR, 8'h80, 8'h01, 8'h81, 4'b1000, 1, "or_80_01");
    tick();
    applyStimulus(OP_NOP, 8'h05, 8'h03, 8'h00, 4'b0001, 1, "nop");
    tick();
    tick();

    applyStimulus(OP_ADD, 8'h01, 8'h01, 8'h02, 4'b0000, 1, "b2b_add");
    tick();
    applyStimulus(OP_XOR, 8'hAA, 8'hFF, 8'h55, 4'b0000, 1, "b2b_xor");
    tick();
    checkVal("b2b_ready", {31'b0, o_ready}, 32'd1);
    tick();
    tick();

`ifdef ALU_SEQ_MUL_EN
    applyStimulus(OP_MUL, 8'h0F, 8'h11, 8'hFF, 4'b1000, WIDTH + 1, "mul_0f_11");
    for (int i = 0; i < WIDTH; i++) begin
      tick();
      checkVal("mul_busy_ready", {31'b0, o_ready}, 32'd0);
      if (i == 2) driveLoad(OP_ADD, 8'hFF, 8'hFF);
    end
    tick();
    checkVal("mul_done_ready", {31'b0, o_ready}, 32'd1);
    applyStimulus(OP_ADD, 8'h01, 8'h02, 8'h03, 4'b0000, 1, "add_in_mul_valid");
    tick();
    applyStimulus(OP_MUL, 8'h10, 8'h10, 8'h00, 4'b0011, WIDTH + 1, "mul_10_10");
    repeat (WIDTH + 1) tick();
    tick();

    driveLoad(OP_MUL, 8'h0F, 8'h11);
    repeat (3) tick();
    i_reset    = 1'b1;
    modelDout  = '0;
    modelFlags = '0;
    tick();
    checkVal("midmul_rst_valid", {31'b0, o_valid}, 32'd0);
    checkVal("midmul_rst_ready", {31'b0, o_ready}, 32'd1);
    checkVal("midmul_rst_dout", {24'b0, o_dout}, 32'h00);
    i_reset = 1'b0;
    repeat (WIDTH + 4) tick();
`else
    applyStimulus(OP_MUL, 8'h05, 8'h03, 8'h00, 4'b0001, 1, "op111_as_nop");
    tick();
    checkVal("op111_ready", {31'b0, o_ready}, 32'd1);
    tick();
`endif

    for (int i = 0; i < 20 && expQ.size() != 0; i++) tick();
    checkVal("scoreboard_drained", expQ.size(), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
